mem_arbiter: RTL and testbench



---
 rtl/mem_arbiter_if.sv | 39 +++
 rtl/mem_arbiter.sv | 112 +++++++++++
 tb/tb_mem_arbiter.sv | 472 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_if.sv
// Bus bundle between the IF/MEM pipeline stages, the arbiter and the unified memory.
// The slave modport is the arbiter's view; master is the environment's view.
interface mem_arbiter_if #(
    parameter int unsigned AW = 32,
    parameter int unsigned DW = 32
);
    logic          i_req;
    logic [AW-1:0] i_addr;
    logic [DW-1:0] i_rdata;
    logic          i_ack;

    logic          d_req;
    logic          d_we;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata;
    logic [DW-1:0] d_rdata;
    logic          d_ack;

    logic          m_en;
    logic          m_we;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wdata;
    logic [DW-1:0] m_rdata;

    logic          stall_if;
    logic          stall_mem;

    modport slave (
        input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, m_rdata,
        output i_rdata, i_ack, d_rdata, d_ack, m_en, m_we, m_addr, m_wdata,
        output stall_if, stall_mem
    );

    modport master (
        output i_req, i_addr, d_req, d_we, d_addr, d_wdata, m_rdata,
        input  i_rdata, i_ack, d_rdata, d_ack, m_en, m_we, m_addr, m_wdata,
        input  stall_if, stall_mem
    );
endinterface

// File: rtl/mem_arbiter.sv
// Arbitrates a single-ported fixed-latency memory between instruction fetch and data access.
// Each access: grant in IDLE, MEM_LAT cycles of ACCESS, one-cycle ack in DONE.
module mem_arbiter #(
    parameter int unsigned AW      = 32,
    parameter int unsigned DW      = 32,
    parameter int unsigned MEM_LAT = 2
) (
    input logic          clk,
    input logic          reset,
    mem_arbiter_if.slave bus
);
    localparam int unsigned CW = $clog2(MEM_LAT) + 1;

    typedef enum logic [1:0] {StIdle, StAccess, StDone} state_e;
    typedef enum logic {OwnI, OwnD} owner_e;

    state_e        state_q;
    owner_e        owner_q;
    owner_e        last_grant_q;
    logic [CW-1:0] cnt_q;
    logic          i_ack_q;
    logic          d_ack_q;
    logic [DW-1:0] i_rdata_q;
    logic [DW-1:0] d_rdata_q;
    logic          m_en_q;
    logic          m_we_q;
    logic [AW-1:0] m_addr_q;
    logic [DW-1:0] m_wdata_q;
    logic          grant_data;

    // Data wins when alone, or when both contend and fetch was served last.
    always_comb begin
        grant_data = bus.d_req && (!bus.i_req || (last_grant_q == OwnI));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= StIdle;
            owner_q      <= OwnI;
            last_grant_q <= OwnI;
            cnt_q        <= '0;
            i_ack_q      <= 1'b0;
            d_ack_q      <= 1'b0;
            i_rdata_q    <= '0;
            d_rdata_q    <= '0;
            m_en_q       <= 1'b0;
            m_we_q       <= 1'b0;
            m_addr_q     <= '0;
            m_wdata_q    <= '0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (bus.i_req || bus.d_req) begin
                        state_q <= StAccess;
                        cnt_q   <= CW'(MEM_LAT - 1);
                        m_en_q  <= 1'b1;
                        if (grant_data) begin
                            owner_q      <= OwnD;
                            last_grant_q <= OwnD;
                            m_we_q       <= bus.d_we;
                            m_addr_q     <= bus.d_addr;
                            m_wdata_q    <= bus.d_wdata;
                        end else begin
                            owner_q      <= OwnI;
                            last_grant_q <= OwnI;
                            m_we_q       <= 1'b0;
                            m_addr_q     <= bus.i_addr;
                        end
                    end
                end
                StAccess: begin
                    if (cnt_q != '0) begin
                        cnt_q <= cnt_q - CW'(1);
                    end else begin
                        state_q <= StDone;
                        m_en_q  <= 1'b0;
                        m_we_q  <= 1'b0;
                        // m_we_q still holds the access direction on this edge.
                        if (owner_q == OwnD) begin
                            d_ack_q <= 1'b1;
                            if (!m_we_q) begin
                                d_rdata_q <= bus.m_rdata;
                            end
                        end else begin
                            i_ack_q   <= 1'b1;
                            i_rdata_q <= bus.m_rdata;
                        end
                    end
                end
                StDone: begin
                    state_q <= StIdle;
                    i_ack_q <= 1'b0;
                    d_ack_q <= 1'b0;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign bus.i_ack     = i_ack_q;
    assign bus.d_ack     = d_ack_q;
    assign bus.i_rdata   = i_rdata_q;
    assign bus.d_rdata   = d_rdata_q;
    assign bus.m_en      = m_en_q;
    assign bus.m_we      = m_we_q;
    assign bus.m_addr    = m_addr_q;
    assign bus.m_wdata   = m_wdata_q;
    assign bus.stall_if  = bus.i_req & ~i_ack_q;
    assign bus.stall_mem = bus.d_req & ~d_ack_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios on MEM_LAT=2 and MEM_LAT=1
// instances, plus randomized traffic against a cycle-timeline reference model.
module tb_mem_arbiter;
    localparam int unsigned AW   = 32;
    localparam int unsigned DW   = 32;
    localparam int unsigned LAT  = 2;
    localparam int unsigned LAT1 = 1;
    localparam logic [31:0] K1   = 32'h1357_9BDF;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    mem_arbiter_if #(.AW(AW), .DW(DW)) bus0 ();
    mem_arbiter_if #(.AW(AW), .DW(DW)) bus1 ();

    mem_arbiter #(.AW(AW), .DW(DW), .MEM_LAT(LAT)) dut0 (.clk(clk), .reset(reset), .bus(bus0));
    mem_arbiter #(.AW(AW), .DW(DW), .MEM_LAT(LAT1)) dut1 (.clk(clk), .reset(reset), .bus(bus1));

    int n_cmp = 0;
    int n_fail = 0;

    logic [31:0] mem [logic [31:0]];
    logic [31:0] ref_mem [logic [31:0]];
    int en_run = 0;

    function automatic logic [31:0] dflt(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'hA5A5_1234;
    endfunction

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        if (mem.exists(a)) return mem[a];
        return dflt(a);
    endfunction

    function automatic logic [31:0] ref_rd(input logic [31:0] a);
        if (ref_mem.exists(a)) return ref_mem[a];
        return dflt(a);
    endfunction

    function automatic logic [31:0] rnd_addr();
        return 32'h2000_0000 | {27'd0, 3'($urandom_range(0, 7)), 2'b00};
    endfunction

    // Memory for dut0: data is valid only in the last access cycle, garbage before that.
    always @(negedge clk) begin
        if (bus0.m_en === 1'b1) en_run = en_run + 1;
        else en_run = 0;
        if (bus0.m_en === 1'b1 && en_run == LAT) begin
            if (bus0.m_we) mem[bus0.m_addr] = bus0.m_wdata;
            bus0.m_rdata = mem_rd(bus0.m_addr);
        end else begin
            bus0.m_rdata = $urandom;
        end
    end

    assign bus1.m_rdata = bus1.m_addr ^ K1;

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        next_cycle();
        reset = 1'b1;
        next_cycle();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        next_cycle();
        reset = 1'b1;
        bus0.i_req = 1'b1; bus0.i_addr = 32'h0040_0010;
        bus0.d_req = 1'b1; bus0.d_we = 1'b0; bus0.d_addr = 32'h1001_0080;
        for (int c = 0; c <= 5; c++) begin
            if (c > 0) next_cycle();
            if (c == 2) reset = 1'b0;
            @(negedge clk);
            if (c == 1 || c == 2) begin
                n_cmp++;
                if ({bus0.i_ack, bus0.d_ack, bus0.i_rdata, bus0.d_rdata, bus0.m_en, bus0.m_we,
                     bus0.m_addr, bus0.m_wdata} !== '0) begin
                    n_fail++;
                    $display("FAIL reset_outputs c=%0d: got %h want 0", c,
                             {bus0.i_ack, bus0.d_ack, bus0.i_rdata, bus0.d_rdata, bus0.m_en,
                              bus0.m_we, bus0.m_addr, bus0.m_wdata});
                end
            end
            if (c == 3) begin
                n_cmp++;
                if ({bus0.m_en, bus0.m_addr} !== {1'b1, 32'h1001_0080}) begin
                    n_fail++;
                    $display("FAIL reset_first_grant: got en=%b addr=%h want en=1 addr=10010080",
                             bus0.m_en, bus0.m_addr);
                end
            end
            if (c == 5) begin
                n_cmp++;
                if ({bus0.d_ack, bus0.i_ack} !== 2'b10) begin
                    n_fail++;
                    $display("FAIL reset_first_ack: got d/i=%b want 10", {bus0.d_ack, bus0.i_ack});
                end
            end
        end
        next_cycle();
        bus0.i_req = 1'b0; bus0.d_req = 1'b0;
    endtask

    task automatic test_fetch();
        apply_reset();
        bus0.i_req = 1'b1; bus0.i_addr = 32'h0040_0000;
        for (int c = 0; c <= 4; c++) begin
            if (c > 0) next_cycle();
            if (c == 4) bus0.i_req = 1'b0;
            @(negedge clk);
            n_cmp++;
            if ({bus0.m_en, bus0.m_we} !== {1'(c == 1 || c == 2), 1'b0}) begin
                n_fail++;
                $display("FAIL fetch_m_en c=%0d: got en/we=%b%b", c, bus0.m_en, bus0.m_we);
            end
            n_cmp++;
            if ({bus0.i_ack, bus0.d_ack} !== {1'(c == 3), 1'b0}) begin
                n_fail++;
                $display("FAIL fetch_ack c=%0d: got i/d=%b%b want %b0", c, bus0.i_ack,
                         bus0.d_ack, 1'(c == 3));
            end
            n_cmp++;
            if (bus0.stall_if !== 1'(c < 3)) begin
                n_fail++;
                $display("FAIL fetch_stall_if c=%0d: got %b want %b", c, bus0.stall_if, 1'(c < 3));
            end
            if (c == 1 || c == 2) begin
                n_cmp++;
                if (bus0.m_addr !== 32'h0040_0000) begin
                    n_fail++;
                    $display("FAIL fetch_m_addr c=%0d: got %h want 00400000", c, bus0.m_addr);
                end
            end
            if (c == 3) begin
                n_cmp++;
                if (bus0.i_rdata !== 32'h2010_0005) begin
                    n_fail++;
                    $display("FAIL fetch_rdata: got %h want 20100005", bus0.i_rdata);
                end
            end
        end
    endtask

    task automatic test_priority();
        apply_reset();
        bus0.i_req = 1'b1; bus0.i_addr = 32'h0040_0004;
        bus0.d_req = 1'b1; bus0.d_we = 1'b0; bus0.d_addr = 32'h1001_0040;
        for (int c = 0; c <= 8; c++) begin
            if (c > 0) next_cycle();
            if (c == 4) bus0.d_req = 1'b0;
            if (c == 8) bus0.i_req = 1'b0;
            @(negedge clk);
            n_cmp++;
            if ({bus0.d_ack, bus0.i_ack} !== {1'(c == 3), 1'(c == 7)}) begin
                n_fail++;
                $display("FAIL prio_acks c=%0d: got d/i=%b%b want %b%b", c, bus0.d_ack,
                         bus0.i_ack, 1'(c == 3), 1'(c == 7));
            end
            n_cmp++;
            if ({bus0.stall_if, bus0.stall_mem} !== {1'(c < 7), 1'(c < 3)}) begin
                n_fail++;
                $display("FAIL prio_stalls c=%0d: got if/mem=%b%b want %b%b", c, bus0.stall_if,
                         bus0.stall_mem, 1'(c < 7), 1'(c < 3));
            end
            if (c == 3) begin
                n_cmp++;
                if (bus0.d_rdata !== 32'h0BAD_F00D) begin
                    n_fail++;
                    $display("FAIL prio_d_rdata: got %h want 0badf00d", bus0.d_rdata);
                end
            end
            if (c == 5) begin
                n_cmp++;
                if (bus0.m_addr !== 32'h0040_0004) begin
                    n_fail++;
                    $display("FAIL prio_i_addr: got %h want 00400004", bus0.m_addr);
                end
            end
            if (c == 7) begin
                n_cmp++;
                if (bus0.i_rdata !== dflt(32'h0040_0004)) begin
                    n_fail++;
                    $display("FAIL prio_i_rdata: got %h want %h", bus0.i_rdata,
                             dflt(32'h0040_0004));
                end
            end
        end
    endtask

    task automatic test_store();
        next_cycle();
        bus0.d_req = 1'b1; bus0.d_we = 1'b1;
        bus0.d_addr = 32'h1001_0000; bus0.d_wdata = 32'hDEAD_BEEF;
        for (int c = 0; c <= 4; c++) begin
            if (c > 0) next_cycle();
            if (c == 1) begin
                bus0.d_addr = 32'h1234_5678; bus0.d_wdata = 32'h0; bus0.d_we = 1'b0;
            end
            if (c == 4) bus0.d_req = 1'b0;
            @(negedge clk);
            n_cmp++;
            if ({bus0.m_en, bus0.m_we} !== {2{1'(c == 1 || c == 2)}}) begin
                n_fail++;
                $display("FAIL store_we c=%0d: got en/we=%b%b", c, bus0.m_en, bus0.m_we);
            end
            if (c == 1 || c == 2) begin
                n_cmp++;
                if ({bus0.m_addr, bus0.m_wdata} !== {32'h1001_0000, 32'hDEAD_BEEF}) begin
                    n_fail++;
                    $display("FAIL store_bus c=%0d: got %h/%h want 10010000/deadbeef", c,
                             bus0.m_addr, bus0.m_wdata);
                end
            end
            n_cmp++;
            if (bus0.d_ack !== 1'(c == 3)) begin
                n_fail++;
                $display("FAIL store_ack c=%0d: got %b want %b", c, bus0.d_ack, 1'(c == 3));
            end
            n_cmp++;
            if (bus0.d_rdata !== 32'h0BAD_F00D) begin
                n_fail++;
                $display("FAIL store_rdata_kept c=%0d: got %h want 0badf00d", c, bus0.d_rdata);
            end
        end
        // Load back what was stored.
        next_cycle();
        bus0.d_req = 1'b1; bus0.d_we = 1'b0; bus0.d_addr = 32'h1001_0000;
        for (int c = 0; c <= 4; c++) begin
            if (c > 0) next_cycle();
            if (c == 4) bus0.d_req = 1'b0;
            @(negedge clk);
            if (c == 3) begin
                n_cmp++;
                if ({bus0.d_ack, bus0.d_rdata} !== {1'b1, 32'hDEAD_BEEF}) begin
                    n_fail++;
                    $display("FAIL store_readback: got ack=%b data=%h want 1/deadbeef",
                             bus0.d_ack, bus0.d_rdata);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        apply_reset();
        bus0.i_req = 1'b1; bus0.i_addr = 32'h0040_0008;
        for (int c = 0; c <= 5; c++) begin
            if (c > 0) next_cycle();
            if (c == 1) begin reset = 1'b1; bus0.i_req = 1'b0; end
            if (c == 2) reset = 1'b0;
            @(negedge clk);
            if (c == 1) begin
                n_cmp++;
                if (bus0.m_en !== 1'b1) begin
                    n_fail++;
                    $display("FAIL midrst_started: got m_en=%b want 1", bus0.m_en);
                end
            end
            if (c >= 2) begin
                n_cmp++;
                if ({bus0.m_en, bus0.m_we, bus0.i_ack, bus0.i_rdata} !== '0) begin
                    n_fail++;
                    $display("FAIL midrst_quiet c=%0d: got en=%b we=%b ack=%b rdata=%h want 0",
                             c, bus0.m_en, bus0.m_we, bus0.i_ack, bus0.i_rdata);
                end
            end
        end
        next_cycle();
        bus0.i_req = 1'b1; bus0.i_addr = 32'h0040_0000;
        for (int c = 0; c <= 4; c++) begin
            if (c > 0) next_cycle();
            if (c == 4) bus0.i_req = 1'b0;
            @(negedge clk);
            n_cmp++;
            if (bus0.i_ack !== 1'(c == 3)) begin
                n_fail++;
                $display("FAIL midrst_retry_ack c=%0d: got %b want %b", c, bus0.i_ack, 1'(c == 3));
            end
            if (c == 3) begin
                n_cmp++;
                if (bus0.i_rdata !== 32'h2010_0005) begin
                    n_fail++;
                    $display("FAIL midrst_retry_rdata: got %h want 20100005", bus0.i_rdata);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0] order;
        int acks[$];
        apply_reset();
        order = '0;
        bus0.i_req = 1'b1; bus0.i_addr = 32'h0040_0000;
        bus0.d_req = 1'b1; bus0.d_we = 1'b0; bus0.d_addr = 32'h1001_0000;
        for (int c = 0; c <= 15; c++) begin
            if (c > 0) next_cycle();
            @(negedge clk);
            n_cmp++;
            if ((bus0.i_ack & bus0.d_ack) !== 1'b0) begin
                n_fail++;
                $display("FAIL b2b_mutex c=%0d: got i/d=%b%b", c, bus0.i_ack, bus0.d_ack);
            end
            if (bus0.i_ack === 1'b1 || bus0.d_ack === 1'b1) begin
                order = {order[2:0], bus0.d_ack};
                acks.push_back(c);
            end
        end
        next_cycle();
        bus0.i_req = 1'b0; bus0.d_req = 1'b0;
        n_cmp++;
        if (acks.size() != 4 || order !== 4'b1010) begin
            n_fail++;
            $display("FAIL b2b_order: got %0d acks order %b want 4 acks order 1010",
                     acks.size(), order);
        end
        for (int k = 0; k < acks.size() && k < 4; k++) begin
            n_cmp++;
            if (acks[k] != 3 + 4 * k) begin
                n_fail++;
                $display("FAIL b2b_ack_cycle k=%0d: got %0d want %0d", k, acks[k], 3 + 4 * k);
            end
        end

        // Same contention on the single-cycle-latency instance.
        bus1.i_req = 1'b1; bus1.i_addr = 32'h0040_0100;
        bus1.d_req = 1'b1; bus1.d_we = 1'b0; bus1.d_addr = 32'h1001_0100;
        for (int c = 0; c <= 11; c++) begin
            if (c > 0) next_cycle();
            @(negedge clk);
            n_cmp++;
            if ({bus1.m_en, bus1.d_ack, bus1.i_ack} !==
                {1'(c % 3 == 1), 1'(c % 6 == 2), 1'(c % 6 == 5)}) begin
                n_fail++;
                $display("FAIL lat1_seq c=%0d: got en/d/i=%b%b%b want %b%b%b", c, bus1.m_en,
                         bus1.d_ack, bus1.i_ack, 1'(c % 3 == 1), 1'(c % 6 == 2), 1'(c % 6 == 5));
            end
            if (c % 6 == 2) begin
                n_cmp++;
                if (bus1.d_rdata !== (32'h1001_0100 ^ K1)) begin
                    n_fail++;
                    $display("FAIL lat1_d_rdata c=%0d: got %h want %h", c, bus1.d_rdata,
                             32'h1001_0100 ^ K1);
                end
            end
            if (c % 6 == 5) begin
                n_cmp++;
                if (bus1.i_rdata !== (32'h0040_0100 ^ K1)) begin
                    n_fail++;
                    $display("FAIL lat1_i_rdata c=%0d: got %h want %h", c, bus1.i_rdata,
                             32'h0040_0100 ^ K1);
                end
            end
        end
        next_cycle();
        bus1.i_req = 1'b0; bus1.d_req = 1'b0;
    endtask

    // Reference: an access granted in cycle g occupies the memory in g+1..g+LAT, acks in
    // g+LAT+1, and the next grant may happen in g+LAT+2.
    task automatic test_random();
        bit busy = 0, own_d = 0, own_we = 0, last_d = 0, i_hold = 0, d_hold = 0;
        bit e_en, e_we, e_ia, e_da;
        int g_cyc = 0, k;
        logic [31:0] own_addr = '0, own_wdata = '0, exp_i_rd = '0, exp_d_rd = '0;
        apply_reset();
        for (int c = 0; c < 600; c++) begin
            if (c > 0) next_cycle();
            if (!i_hold && $urandom_range(0, 2) != 0) begin
                i_hold = 1; bus0.i_addr = rnd_addr();
            end
            if (!d_hold && $urandom_range(0, 2) != 0) begin
                d_hold = 1; bus0.d_we = 1'($urandom_range(0, 1));
                bus0.d_addr = rnd_addr(); bus0.d_wdata = $urandom;
            end
            if (busy && own_d) begin
                bus0.d_addr = $urandom; bus0.d_wdata = $urandom;
                bus0.d_we = 1'($urandom_range(0, 1));
            end else if (busy) begin
                bus0.i_addr = $urandom;
            end
            bus0.i_req = i_hold;
            bus0.d_req = d_hold;
            e_en = 0; e_we = 0; e_ia = 0; e_da = 0;
            if (busy) begin
                k = c - g_cyc;
                if (k >= 1 && k <= int'(LAT)) begin e_en = 1; e_we = own_we; end
                if (k == int'(LAT) + 1) begin
                    busy = 0;
                    if (own_d) begin
                        e_da = 1; d_hold = 0;
                        if (own_we) ref_mem[own_addr] = own_wdata;
                        else exp_d_rd = ref_rd(own_addr);
                    end else begin
                        e_ia = 1; i_hold = 0; exp_i_rd = ref_rd(own_addr);
                    end
                end
            end else if (i_hold || d_hold) begin
                own_d = d_hold && (!i_hold || !last_d);
                last_d = own_d;
                own_we = own_d ? bus0.d_we : 1'b0;
                own_addr = own_d ? bus0.d_addr : bus0.i_addr;
                own_wdata = bus0.d_wdata;
                busy = 1; g_cyc = c;
            end
            @(negedge clk);
            n_cmp++;
            if ({bus0.m_en, bus0.m_we, bus0.i_ack, bus0.d_ack} !== {e_en, e_we, e_ia, e_da}) begin
                n_fail++;
                $display("FAIL rnd_ctrl c=%0d: got en/we/ia/da=%b%b%b%b want %b%b%b%b", c,
                         bus0.m_en, bus0.m_we, bus0.i_ack, bus0.d_ack, e_en, e_we, e_ia, e_da);
            end
            n_cmp++;
            if ({bus0.stall_if, bus0.stall_mem} !== {i_hold & ~e_ia, d_hold & ~e_da}
                && !(e_ia || e_da)) begin
                n_fail++;
                $display("FAIL rnd_stall c=%0d: got if/mem=%b%b want %b%b", c, bus0.stall_if,
                         bus0.stall_mem, i_hold, d_hold);
            end
            n_cmp++;
            if ({bus0.i_rdata, bus0.d_rdata} !== {exp_i_rd, exp_d_rd}) begin
                n_fail++;
                $display("FAIL rnd_rdata c=%0d: got i=%h d=%h want i=%h d=%h", c, bus0.i_rdata,
                         bus0.d_rdata, exp_i_rd, exp_d_rd);
            end
            if (e_en) begin
                n_cmp++;
                if (bus0.m_addr !== own_addr || (own_we && bus0.m_wdata !== own_wdata)) begin
                    n_fail++;
                    $display("FAIL rnd_bus c=%0d: got %h/%h want %h/%h", c, bus0.m_addr,
                             bus0.m_wdata, own_addr, own_wdata);
                end
            end
            if (e_ia || e_da) begin
                // Requests were still high through the ack cycle; stall must be low there.
                n_cmp++;
                if ((e_ia && bus0.stall_if !== 1'b0) || (e_da && bus0.stall_mem !== 1'b0)) begin
                    n_fail++;
                    $display("FAIL rnd_stall_ack c=%0d: got if/mem=%b%b", c, bus0.stall_if,
                             bus0.stall_mem);
                end
            end
        end
        next_cycle();
        bus0.i_req = 1'b0; bus0.d_req = 1'b0;
    endtask

    initial begin
        bus0.i_req = 1'b0; bus0.i_addr = '0; bus0.d_req = 1'b0; bus0.d_we = 1'b0;
        bus0.d_addr = '0; bus0.d_wdata = '0;
        bus1.i_req = 1'b0; bus1.i_addr = '0; bus1.d_req = 1'b0; bus1.d_we = 1'b0;
        bus1.d_addr = '0; bus1.d_wdata = '0;
        mem[32'h0040_0000] = 32'h2010_0005;
        mem[32'h1001_0040] = 32'h0BAD_F00D;
        repeat (3) @(posedge clk);
        #1;
        test_reset();
        test_fetch();
        test_priority();
        test_store();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
